// File: rtl/branch_ctrl_if.sv
// Fetch-side bus between the instruction-fetch stage and the branch controller.
// The fetch stage (master) presents PC/Instr/Zero; the controller (slave)
// answers with redirect, squash and halt requests plus a taken-branch count.
interface branch_ctrl_if;
  logic [7:0] pc;
  logic [8:0] instr;
  logic       instr_valid;
  logic       zero;
  logic       branch;
  logic [7:0] target;
  logic       halt;
  logic       squash;
  logic [7:0] branch_count;

  modport master (
    output pc, instr, instr_valid, zero,
    input  branch, target, halt, squash, branch_count
  );

  modport slave (
    input  pc, instr, instr_valid, zero,
    output branch, target, halt, squash, branch_count
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: decodes SETT/JMP/BZ/BNZ/HALT from the fetch stream and
// issues one-cycle redirect + squash pulses or a sticky halt to fetch.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_RUN    | decoding valid instructions
//   ST_SQUASH | redirect cycle: Branch/Squash high, instruction on bus ignored
//   ST_HALTED | terminal stop, Halt high, only i_init leaves
module branch_ctrl (
  input  logic          i_clk,
  input  logic          i_init,
  branch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] OP_SETT = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BNZ  = 4'hD;
  localparam logic [8:0] INSTR_HALT = 9'h1FF;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_tgt_reg;
  logic [7:0] w_tgt_reg_nxt;
  logic [7:0] r_target;
  logic [7:0] w_target_nxt;
  logic [7:0] r_count;
  logic       w_taken;

  logic [3:0] w_opcode;
  logic [7:0] w_offset;
  logic [7:0] w_rel_target;

  assign w_opcode     = bus.instr[8:5];
  // Relative branches carry a signed 5-bit offset; the 8-bit add wraps mod 256.
  assign w_offset     = {{3{bus.instr[4]}}, bus.instr[4:0]};
  assign w_rel_target = bus.pc + w_offset;

  // State register and datapath registers; i_init overrides any decode this edge.
  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_state   <= ST_RUN;
      r_tgt_reg <= 8'h00;
      r_target  <= 8'h00;
      r_count   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_tgt_reg <= w_tgt_reg_nxt;
      r_target  <= w_target_nxt;
      if (w_taken && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'h01;
      end
    end
  end

  // Decode in RUN only; SQUASH always falls back to RUN, HALTED is sticky.
  always_comb begin
    w_state_nxt   = r_state;
    w_tgt_reg_nxt = r_tgt_reg;
    w_target_nxt  = r_target;
    w_taken       = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.instr_valid) begin
          if (bus.instr == INSTR_HALT) begin
            w_state_nxt = ST_HALTED;
          end else begin
            case (w_opcode)
              OP_SETT: begin
                if (bus.instr[4]) begin
                  w_tgt_reg_nxt = {bus.instr[3:0], r_tgt_reg[3:0]};
                end else begin
                  w_tgt_reg_nxt = {r_tgt_reg[7:4], bus.instr[3:0]};
                end
              end
              OP_JMP: begin
                w_taken      = 1'b1;
                w_target_nxt = r_tgt_reg;
              end
              OP_BZ: begin
                if (bus.zero) begin
                  w_taken      = 1'b1;
                  w_target_nxt = w_rel_target;
                end
              end
              OP_BNZ: begin
                if (!bus.zero) begin
                  w_taken      = 1'b1;
                  w_target_nxt = w_rel_target;
                end
              end
              default: begin
              end
            endcase
            if (w_taken) begin
              w_state_nxt = ST_SQUASH;
            end
          end
        end
      end
      ST_SQUASH: begin
        w_state_nxt = ST_RUN;
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Redirect, squash and halt are pure functions of the registered state,
  // so they are glitch-free and Branch can never stay high two cycles.
  assign bus.branch       = (r_state == ST_SQUASH);
  assign bus.squash       = (r_state == ST_SQUASH);
  assign bus.halt         = (r_state == ST_HALTED);
  assign bus.target       = r_target;
  assign bus.branch_count = r_count;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus a randomized
// stream, all compared against an instruction-level reference model.
module tb_branch_ctrl;

  logic clk;
  logic init;
  int   n_checks;
  int   n_errors;

  // Reference model: architectural view of the controller.
  int   m_mode;     // 0 = running, 1 = redirect cycle, 2 = halted
  int   m_tgt;      // target register value
  int   m_target;   // last redirect address
  int   m_count;    // taken-branch count, saturating at 255
  bit   m_branch;
  bit   m_halt;

  branch_ctrl_if bus ();

  branch_ctrl dut (
    .i_clk  (clk),
    .i_init (init),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] I_HALT = 9'h1FF;

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [4:0] low);
    return {op, low};
  endfunction

  // Drive one cycle of stimulus, let the edge happen, advance the model.
  task automatic cyc(input logic i_in, input logic v, input logic [7:0] pc,
                     input logic [8:0] ins, input logic z);
    int  off;
    int  t;
    bit  take;
    @(negedge clk);
    init            = i_in;
    bus.instr_valid = v;
    bus.pc          = pc;
    bus.instr       = ins;
    bus.zero        = z;
    @(posedge clk);
    if (i_in) begin
      m_mode = 0; m_tgt = 0; m_target = 0; m_count = 0;
      m_branch = 0; m_halt = 0;
    end else begin
      m_branch = 0;
      if (m_mode == 1) begin
        m_mode = 0;
      end else if (m_mode == 0 && v) begin
        if (ins == I_HALT) begin
          m_mode = 2;
          m_halt = 1;
        end else begin
          take = 0;
          t    = 0;
          off  = int'(ins[4:0]);
          if (off >= 16) off = off - 32;
          case (ins[8:5])
            4'hA: begin
              if (ins[4]) m_tgt = (m_tgt % 16) + 16 * int'(ins[3:0]);
              else        m_tgt = (m_tgt / 16) * 16 + int'(ins[3:0]);
            end
            4'hB: begin take = 1; t = m_tgt; end
            4'hC: begin take = z;  t = (int'(pc) + off + 256) % 256; end
            4'hD: begin take = !z; t = (int'(pc) + off + 256) % 256; end
            default: ;
          endcase
          if (take) begin
            m_branch = 1;
            m_target = t;
            if (m_count < 255) m_count = m_count + 1;
            m_mode = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    n_checks++;
    if ({bus.branch, bus.squash, bus.halt} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got b/s/h=%b%b%b want 000", bus.branch, bus.squash, bus.halt);
    end
    n_checks++;
    if (bus.target !== 8'h00 || bus.branch_count !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_regs: got target=%h count=%h want 00/00", bus.target, bus.branch_count);
    end
  endtask

  task automatic test_sett_jmp();
    cyc(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 9'h155, 1'b0);   // high nibble 5
    cyc(1'b0, 1'b1, 8'h01, 9'h14A, 1'b0);   // low nibble A
    n_checks++;
    if (bus.branch !== 1'b0) begin
      n_errors++;
      $display("FAIL sett_no_branch: got branch=%b want 0", bus.branch);
    end
    cyc(1'b0, 1'b1, 8'h02, mk(4'hB, 5'h00), 1'b0);
    n_checks++;
    if ({bus.branch, bus.squash} !== 2'b11 || bus.target !== 8'h5A || bus.branch_count !== 8'h01) begin
      n_errors++;
      $display("FAIL jmp_redirect: got b=%b s=%b tgt=%h cnt=%h want 1 1 5a 01",
               bus.branch, bus.squash, bus.target, bus.branch_count);
    end
    cyc(1'b0, 1'b0, 8'h03, 9'h000, 1'b0);
    n_checks++;
    if ({bus.branch, bus.squash} !== 2'b00 || bus.target !== 8'h5A) begin
      n_errors++;
      $display("FAIL jmp_one_cycle: got b=%b s=%b tgt=%h want 0 0 5a", bus.branch, bus.squash, bus.target);
    end
  endtask

  task automatic test_rel_branches();
    cyc(1'b0, 1'b1, 8'h10, mk(4'hC, 5'h1C), 1'b1);
    n_checks++;
    if (bus.branch !== 1'b1 || bus.target !== 8'h0C) begin
      n_errors++;
      $display("FAIL bz_taken: got b=%b tgt=%h want 1 0c", bus.branch, bus.target);
    end
    cyc(1'b0, 1'b0, 8'h11, 9'h000, 1'b0);
    cyc(1'b0, 1'b1, 8'h10, mk(4'hC, 5'h1C), 1'b0);
    n_checks++;
    if (bus.branch !== 1'b0 || bus.squash !== 1'b0 || bus.target !== 8'h0C) begin
      n_errors++;
      $display("FAIL bz_not_taken: got b=%b s=%b tgt=%h want 0 0 0c", bus.branch, bus.squash, bus.target);
    end
    cyc(1'b0, 1'b1, 8'h02, mk(4'hD, 5'h1C), 1'b0);
    n_checks++;
    if (bus.branch !== 1'b1 || bus.target !== 8'hFE) begin
      n_errors++;
      $display("FAIL bnz_wrap_down: got b=%b tgt=%h want 1 fe", bus.branch, bus.target);
    end
    cyc(1'b0, 1'b0, 8'h00, 9'h000, 1'b0);
    cyc(1'b0, 1'b1, 8'hFE, mk(4'hC, 5'h05), 1'b1);
    n_checks++;
    if (bus.branch !== 1'b1 || bus.target !== 8'h03) begin
      n_errors++;
      $display("FAIL bz_wrap_up: got b=%b tgt=%h want 1 03", bus.branch, bus.target);
    end
    cyc(1'b0, 1'b1, 8'h00, mk(4'hD, 5'h01), 1'b1);   // BNZ with Zero=1: not taken
    n_checks++;
    if (bus.branch !== 1'b0 || bus.target !== 8'h03) begin
      n_errors++;
      $display("FAIL bnz_not_taken: got b=%b tgt=%h want 0 03", bus.branch, bus.target);
    end
  endtask

  task automatic test_jmp_then_halt();
    cyc(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    cyc(1'b0, 1'b1, 8'h20, mk(4'hB, 5'h00), 1'b0);
    cyc(1'b0, 1'b1, 8'h21, I_HALT, 1'b0);           // lands in the squash cycle
    cyc(1'b0, 1'b0, 8'h00, 9'h000, 1'b0);
    n_checks++;
    if (bus.halt !== 1'b0 || bus.branch !== 1'b0) begin
      n_errors++;
      $display("FAIL squashed_halt: got halt=%b branch=%b want 0 0", bus.halt, bus.branch);
    end
    cyc(1'b0, 1'b1, 8'h40, mk(4'hC, 5'h02), 1'b1);
    n_checks++;
    if (bus.branch !== 1'b1 || bus.target !== 8'h42) begin
      n_errors++;
      $display("FAIL run_after_squash: got b=%b tgt=%h want 1 42", bus.branch, bus.target);
    end
  endtask

  task automatic test_halt_sticky();
    cyc(1'b0, 1'b0, 8'h00, 9'h000, 1'b0);
    cyc(1'b0, 1'b1, 8'h50, I_HALT, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'($urandom), (i % 2) ? mk(4'hB, 5'h00) : mk(4'hC, 5'($urandom)), 1'b1);
      n_checks++;
      if (bus.halt !== 1'b1 || bus.branch !== 1'b0 || bus.squash !== 1'b0) begin
        n_errors++;
        $display("FAIL halt_sticky[%0d]: got h=%b b=%b s=%b want 1 0 0", i, bus.halt, bus.branch, bus.squash);
      end
    end
    cyc(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    n_checks++;
    if (bus.halt !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_cleared: got halt=%b want 0", bus.halt);
    end
  endtask

  task automatic test_back_to_back_saturate();
    logic prev;
    cyc(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    prev = 1'b0;
    for (int i = 0; i < 520; i++) begin
      cyc(1'b0, 1'b1, 8'(i), mk(4'hB, 5'h00), 1'b0);
      n_checks++;
      if (bus.branch !== ~prev) begin
        n_errors++;
        $display("FAIL b2b_alternate[%0d]: got branch=%b want %b", i, bus.branch, ~prev);
      end
      prev = bus.branch;
    end
    n_checks++;
    if (bus.branch_count !== 8'hFF) begin
      n_errors++;
      $display("FAIL count_saturate: got %h want ff", bus.branch_count);
    end
    cyc(1'b1, 1'b1, 8'h00, mk(4'hB, 5'h00), 1'b0);
    n_checks++;
    if (bus.branch !== 1'b0 || bus.branch_count !== 8'h00) begin
      n_errors++;
      $display("FAIL init_over_jmp: got b=%b cnt=%h want 0 00", bus.branch, bus.branch_count);
    end
  endtask

  task automatic test_random();
    logic [8:0] ins;
    logic       iv;
    logic       in_init;
    int         sel;
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 19);
      case (sel)
        0, 1, 2:  ins = mk(4'hA, 5'($urandom));
        3, 4:     ins = mk(4'hB, 5'($urandom));
        5, 6, 7:  ins = mk(4'hC, 5'($urandom));
        8, 9, 10: ins = mk(4'hD, 5'($urandom));
        11:       ins = ($urandom_range(0, 3) == 0) ? I_HALT : 9'($urandom);
        default:  ins = 9'($urandom);
      endcase
      iv      = ($urandom_range(0, 7) != 0);
      in_init = ($urandom_range(0, 39) == 0);
      cyc(in_init, iv, 8'($urandom), ins, 1'($urandom));
      n_checks++;
      if ({bus.branch, bus.squash, bus.halt, bus.target, bus.branch_count} !==
          {m_branch, m_branch, m_halt, 8'(m_target), 8'(m_count)}) begin
        n_errors++;
        $display("FAIL random[%0d]: got b=%b s=%b h=%b tgt=%h cnt=%h want b=%b s=%b h=%b tgt=%h cnt=%h",
                 i, bus.branch, bus.squash, bus.halt, bus.target, bus.branch_count,
                 m_branch, m_branch, m_halt, 8'(m_target), 8'(m_count));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_mode = 0; m_tgt = 0; m_target = 0; m_count = 0; m_branch = 0; m_halt = 0;
    init            = 1'b1;
    bus.instr_valid = 1'b0;
    bus.pc          = 8'h00;
    bus.instr       = 9'h000;
    bus.zero        = 1'b0;
    test_reset();
    test_sett_jmp();
    test_rel_branches();
    test_jmp_then_halt();
    test_halt_sticky();
    test_back_to_back_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
